// File: rtl/sar_seq_if.sv
// Bundle of sequencer control, SAR converter handshake and result stream signals.
// master = sequencer side, slave = environment (SAR front end, control, result sink).
interface sar_seq_if #(
  parameter int SIZE = 8,
  parameter int NCH  = 4
);
  localparam int CW = $clog2(NCH);

  logic            en;
  logic            trig;
  logic            cont;
  logic [NCH-1:0]  ch_mask;
  logic            sar_start;
  logic            sar_done;
  logic [SIZE-1:0] sar_data;
  logic [CW-1:0]   ch_sel;
  logic            sample;
  logic [SIZE-1:0] data_out;
  logic [CW-1:0]   data_ch;
  logic            data_valid;
  logic            data_ready;
  logic            busy;
  logic            eos;
  logic            err;

  modport master (
    input  en, trig, cont, ch_mask, sar_done, sar_data, data_ready,
    output sar_start, ch_sel, sample, data_out, data_ch, data_valid, busy, eos, err
  );

  modport slave (
    output en, trig, cont, ch_mask, sar_done, sar_data, data_ready,
    input  sar_start, ch_sel, sample, data_out, data_ch, data_valid, busy, eos, err
  );
endinterface

// File: rtl/sar_seq.sv
// SAR scan sequencer: walks the latched channel mask, runs sample/convert per channel, streams results.
// Optional macro SAR_SEQ_AVG_EN: four conversions per channel, delivered as their truncated mean.
module sar_seq #(
  parameter int SIZE          = 8,
  parameter int NCH           = 4,
  parameter int SAMPLE_CYCLES = 4,
  parameter int TIMEOUT       = SIZE + 4
) (
  input  logic     clk,
  input  logic     rst,
  sar_seq_if.master bus
);
  localparam int CW = $clog2(NCH);
  localparam int SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SAMPLE, CONV, HOLD, NEXT} state_t;

  state_t          state_q;
  logic [NCH-1:0]  mask_q;
  logic [CW-1:0]   ch_sel_q;
  logic [CW-1:0]   data_ch_q;
  logic [SW-1:0]   scnt_q;
  logic [TW-1:0]   tcnt_q;
  logic [SIZE-1:0] pend_q;
  logic [SIZE-1:0] data_out_q;
  logic            sar_start_q;
  logic            sample_q;
  logic            data_valid_q;
  logic            busy_q;
  logic            eos_q;
  logic            err_q;

  logic [CW-1:0]   first_ch;
  logic [CW-1:0]   next_ch;
  logic            next_vld;
  logic [SIZE-1:0] res_d;
  logic            out_free;

`ifdef SAR_SEQ_AVG_EN
  logic [1:0]      avg_q;
  logic [SIZE+1:0] acc_q;
  logic [SIZE+1:0] acc_sum;

  // First conversion of a channel starts the sum fresh, so no clear is needed between channels.
  assign acc_sum = ((avg_q == 2'd0) ? '0 : acc_q) + {2'b00, bus.sar_data};
  assign res_d   = acc_sum[SIZE+1:2];
`else
  assign res_d   = bus.sar_data;
`endif

  assign out_free = !data_valid_q || bus.data_ready;

  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    next_vld = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.ch_mask[i]) first_ch = CW'(i);
      if (mask_q[i] && (i > int'(ch_sel_q))) begin
        next_ch  = CW'(i);
        next_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      ch_sel_q     <= '0;
      data_ch_q    <= '0;
      scnt_q       <= '0;
      tcnt_q       <= '0;
      pend_q       <= '0;
      data_out_q   <= '0;
      sar_start_q  <= 1'b0;
      sample_q     <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      eos_q        <= 1'b0;
      err_q        <= 1'b0;
`ifdef SAR_SEQ_AVG_EN
      avg_q        <= '0;
      acc_q        <= '0;
`endif
    end else begin
      sar_start_q <= 1'b0;
      eos_q       <= 1'b0;
      if (data_valid_q && bus.data_ready) data_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.en && bus.trig && (|bus.ch_mask)) begin
            mask_q   <= bus.ch_mask;
            ch_sel_q <= first_ch;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            sample_q <= 1'b1;
            scnt_q   <= '0;
            state_q  <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (scnt_q == SW'(SAMPLE_CYCLES - 1)) begin
            sample_q    <= 1'b0;
            sar_start_q <= 1'b1;
            tcnt_q      <= '0;
            state_q     <= CONV;
          end else begin
            scnt_q <= scnt_q + 1'b1;
          end
        end
        CONV: begin
          if (bus.sar_done) begin
`ifdef SAR_SEQ_AVG_EN
            avg_q <= avg_q + 1'b1;
            if (avg_q != 2'd3) begin
              acc_q    <= acc_sum;
              sample_q <= 1'b1;
              scnt_q   <= '0;
              state_q  <= SAMPLE;
            end else
`endif
            if (out_free) begin
              data_out_q   <= res_d;
              data_ch_q    <= ch_sel_q;
              data_valid_q <= 1'b1;
              state_q      <= NEXT;
            end else begin
              pend_q  <= res_d;
              state_q <= HOLD;
            end
          end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef SAR_SEQ_AVG_EN
            avg_q   <= '0;
`endif
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (bus.data_ready) begin
            data_out_q   <= pend_q;
            data_ch_q    <= ch_sel_q;
            data_valid_q <= 1'b1;
            state_q      <= NEXT;
          end
        end
        NEXT: begin
          // Dropping en ends the scan quietly once the current result is out.
          if (!bus.en) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (next_vld) begin
            ch_sel_q <= next_ch;
            sample_q <= 1'b1;
            scnt_q   <= '0;
            state_q  <= SAMPLE;
          end else begin
            eos_q <= 1'b1;
            if (bus.cont && (|bus.ch_mask)) begin
              mask_q   <= bus.ch_mask;
              ch_sel_q <= first_ch;
              sample_q <= 1'b1;
              scnt_q   <= '0;
              state_q  <= SAMPLE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.sar_start  = sar_start_q;
  assign bus.sample     = sample_q;
  assign bus.ch_sel     = ch_sel_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_ch    = data_ch_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = busy_q;
  assign bus.eos        = eos_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_sar_seq.sv
// Bench for sar_seq: directed scenarios and randomized scans checked against a
// channel-value reference model (expected stream = set mask bits ascending, each with its channel value).
module tb_sar_seq;
  localparam int SIZE = 8;
  localparam int NCH  = 4;
  localparam int SC   = 4;
  localparam int TO   = SIZE + 4;
  localparam int CW   = $clog2(NCH);
`ifdef SAR_SEQ_AVG_EN
  localparam int NCONV = 4;
  localparam int HOLDW = 60;
  localparam int OFFS [4] = '{0, 1, 2, 4};
`else
  localparam int NCONV = 1;
  localparam int HOLDW = 20;
`endif

  logic clk = 1'b0;
  logic rst;

  sar_seq_if #(.SIZE(SIZE), .NCH(NCH)) bus ();

  sar_seq #(.SIZE(SIZE), .NCH(NCH), .SAMPLE_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [SIZE-1:0] chan_val [NCH];
  bit              mute    = 1'b0;
  bit              rnd_rdy = 1'b0;
  bit              fix_rdy = 1'b1;
  int              scan_id = 0;

  int              n_start = 0;
  int              n_eos   = 0;
  int              got_n   = 0;
  int              bad     = 0;
  int              got_ch  [512];
  logic [SIZE-1:0] got_dat [512];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SIZE-1:0] exp_val(input logic [SIZE-1:0] v);
`ifdef SAR_SEQ_AVG_EN
    int s = 4 * int'(v) + 7;
    return SIZE'(s / 4);
`else
    return v;
`endif
  endfunction

  // Result sink readiness: random when requested, otherwise a fixed level.
  initial begin
    bus.data_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.data_ready = rnd_rdy ? ($urandom_range(0, 1) != 0) : fix_rdy;
    end
  end

  // SAR front end: converts the value of the channel the mux points at.
  initial begin : sar_model
    int lat;
    int k;
    int last_id;
    logic [CW-1:0] ch;
    bus.sar_done = 1'b0;
    bus.sar_data = '0;
    k       = 0;
    last_id = -1;
    forever begin
      @(negedge clk);
      bus.sar_done = 1'b0;
      if (bus.sar_start && !mute) begin
        if (scan_id != last_id) begin
          k       = 0;
          last_id = scan_id;
        end
        ch  = bus.ch_sel;
        lat = $urandom_range(0, 6);
        repeat (lat) @(negedge clk);
`ifdef SAR_SEQ_AVG_EN
        bus.sar_data = chan_val[ch] + SIZE'(OFFS[k % 4]);
        k++;
`else
        bus.sar_data = chan_val[ch];
`endif
        bus.sar_done = 1'b1;
      end
    end
  end

  // Protocol monitor: result capture, pulse counts, sample-window shape.
  initial begin : monitor
    int run;
    logic [CW-1:0] run_ch;
    logic prev_start;
    logic prev_eos;
    run = 0;
    run_ch = '0;
    prev_start = 1'b0;
    prev_eos = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
        prev_start = 1'b0;
        prev_eos = 1'b0;
      end else begin
        if (bus.sar_start) n_start++;
        if (bus.eos) n_eos++;
        if (bus.sar_start && (prev_start || bus.sample)) bad++;
        if (bus.eos && prev_eos) bad++;
        if (!bus.busy && (bus.sample || bus.sar_start)) bad++;
        if (bus.sample) begin
          if (run == 0) run_ch = bus.ch_sel;
          else if (bus.ch_sel != run_ch) bad++;
          run++;
        end else if (run != 0) begin
          if (run != SC) bad++;
          run = 0;
        end
        if (bus.data_valid && bus.data_ready && got_n < 512) begin
          got_ch[got_n]  = int'(bus.data_ch);
          got_dat[got_n] = bus.data_out;
          got_n++;
        end
        prev_start = bus.sar_start;
        prev_eos   = bus.eos;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [NCH-1:0] m, input logic c);
    scan_id++;
    bus.ch_mask = m;
    bus.cont    = c;
    bus.en      = 1'b1;
    bus.trig    = 1'b1;
    tick();
    bus.trig    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || bus.data_valid) && n < 3000);
    check({tag, " idle"}, 32'(bus.busy || bus.data_valid), 0);
  endtask

  task automatic check_scan(input string tag, input logic [NCH-1:0] m, input int base);
    int j = base;
    for (int i = 0; i < NCH; i++) begin
      if (m[i]) begin
        check({tag, " ch"}, 32'(got_ch[j]), 32'(i));
        check({tag, " data"}, 32'(got_dat[j]), 32'(exp_val(chan_val[i])));
        j++;
      end
    end
    check({tag, " count"}, 32'(got_n - base), 32'(j - base));
  endtask

  initial begin : main
    int b;
    int e;
    int s0;
    int n;
    logic [SIZE-1:0] v0;
    bit stable;
    logic [NCH-1:0] m;

    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.trig    = 1'b0;
    bus.cont    = 1'b0;
    bus.ch_mask = '0;
    for (int i = 0; i < NCH; i++) chan_val[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(bus.busy), 0);
    check("rst sample", 32'(bus.sample), 0);
    check("rst sar_start", 32'(bus.sar_start), 0);
    check("rst data_valid", 32'(bus.data_valid), 0);
    check("rst eos_err", 32'({bus.eos, bus.err}), 0);
    check("rst data", 32'({bus.data_out, bus.data_ch, bus.ch_sel}), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Two-channel scan, sink always ready.
    chan_val[1] = 8'h55;
    chan_val[3] = 8'hAA;
    b = got_n;
    e = n_eos;
    start_scan(4'b1010, 1'b0);
    wait_idle("scan1010");
    check_scan("scan1010", 4'b1010, b);
    check("scan1010 eos", 32'(n_eos - e), 1);

    // Sink stalls after the first result.
    fix_rdy = 1'b0;
    tick();
    b  = got_n;
    s0 = n_start;
    start_scan(4'b1010, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.data_valid && n < 300);
    check("stall first valid", 32'(bus.data_valid), 1);
    v0 = bus.data_out;
    stable = 1'b1;
    repeat (HOLDW) begin
      @(negedge clk);
      if (bus.data_out !== v0 || bus.data_valid !== 1'b1 || bus.data_ch !== CW'(1)) stable = 1'b0;
    end
    check("stall stable", 32'(stable), 1);
    check("stall first data", 32'(v0), 32'(exp_val(8'h55)));
    check("stall starts", 32'(n_start - s0), 32'(2 * NCONV));
    check("stall busy", 32'(bus.busy), 1);
    fix_rdy = 1'b1;
    wait_idle("stall");
    check_scan("stall", 4'b1010, b);

    // Continuous mode, en dropped during the third scan's conversion.
    chan_val[0] = SIZE'($urandom_range(0, 248));
    b = got_n;
    e = n_eos;
    start_scan(4'b0001, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((n_eos - e) < 2 && n < 2000);
    check("cont two eos", 32'(n_eos - e), 2);
    n = 0;
    while (!bus.sar_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cont third start", 32'(bus.sar_start), 1);
    bus.en = 1'b0;
    wait_idle("cont");
    bus.cont = 1'b0;
    check("cont results", 32'(got_n - b), 3);
    check("cont eos", 32'(n_eos - e), 2);
    check("cont data", 32'(got_dat[b + 2]), 32'(exp_val(chan_val[0])));
    repeat (10) tick();
    check("cont stays idle", 32'(bus.busy), 0);

    // SAR never answers: timeout.
    mute = 1'b1;
    b = got_n;
    e = n_eos;
    start_scan(4'b0010, 1'b0);
    n = 0;
    while (!bus.sar_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to start seen", 32'(bus.sar_start), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.err && n < 100);
    check("to err delay", 32'(n), 32'(TO));
    check("to idle", 32'(bus.busy), 0);
    check("to no data", 32'({bus.data_valid, 8'(got_n - b)}), 0);
    repeat (5) tick();
    check("to err sticky", 32'(bus.err), 1);
    check("to no eos", 32'(n_eos - e), 0);
    mute = 1'b0;
    chan_val[1] = SIZE'($urandom_range(0, 248));
    b = got_n;
    start_scan(4'b0010, 1'b0);
    check("to err cleared", 32'(bus.err), 0);
    wait_idle("to retry");
    check_scan("to retry", 4'b0010, b);

    // Empty mask: trigger ignored.
    e = n_eos;
    bus.ch_mask = '0;
    bus.trig = 1'b1;
    repeat (3) tick();
    bus.trig = 1'b0;
    @(negedge clk);
    check("empty mask idle", 32'({bus.busy, bus.sample}), 0);
    check("empty mask eos", 32'(n_eos - e), 0);

    // Reset during SAMPLE.
    b = got_n;
    start_scan(4'b1100, 1'b0);
    n = 0;
    while (!bus.sample && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst = 1'b1;
    #1;
    check("mid rst ctrl", 32'({bus.busy, bus.sample, bus.sar_start, bus.data_valid, bus.eos, bus.err}), 0);
    check("mid rst data", 32'({bus.data_out, bus.data_ch, bus.ch_sel}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid rst no result", 32'(got_n - b), 0);
    tick();
    chan_val[1] = SIZE'($urandom_range(0, 248));
    chan_val[2] = SIZE'($urandom_range(0, 248));
    b = got_n;
    start_scan(4'b0110, 1'b0);
    wait_idle("post rst");
    check_scan("post rst", 4'b0110, b);

    // Randomized scans with a randomly stalling sink.
    rnd_rdy = 1'b1;
    for (int it = 0; it < 8; it++) begin
      m = NCH'($urandom_range(1, (1 << NCH) - 1));
      for (int i = 0; i < NCH; i++) chan_val[i] = SIZE'($urandom_range(0, 248));
      b = got_n;
      e = n_eos;
      start_scan(m, 1'b0);
      wait_idle("rand");
      check_scan("rand", m, b);
      check("rand eos", 32'(n_eos - e), 1);
    end
    rnd_rdy = 1'b0;
    tick();

`ifdef SAR_SEQ_AVG_EN
    // Averaging: conversions 10, 11, 12, 14 give 11.
    chan_val[2] = 8'd10;
    b = got_n;
    start_scan(4'b0100, 1'b0);
    wait_idle("avg");
    check("avg count", 32'(got_n - b), 1);
    check("avg ch", 32'(got_ch[b]), 2);
    check("avg data", 32'(got_dat[b]), 11);
`endif

    check("protocol monitor", 32'(bad), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
